// File: rtl/ascii_to_scan.sv
// Encodes one Hack key code into its PS/2 Set-2 make/break byte sequence.
// Optional macro SHIFT_EN adds shifted characters (left-shift wrapped around the base key).
module ascii_to_scan #(
  parameter int unsigned BYTE_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic       busy,
  output logic       unmapped
);

  typedef enum logic [3:0] {
    IDLE, LOOK, SH_MK, MK_E0, MK, BK_E0, BK_F0, BK, SH_F0, SH_BK
  } state_t;

  state_t     state;
  state_t     first;
  state_t     nxt;
  logic [7:0] key_q;
  logic [7:0] gap_cnt;
  logic       gapping;
  logic [9:0] m;
  logic       hit;
  logic       ext;
  logic       shift;
  logic [7:0] code;

  // Unshifted table: {hit, ext, make code}
  function automatic logic [9:0] base_map(input logic [7:0] k);
    logic [9:0] r;
    r = '0;
    case (k)
      8'd97:  r = {2'b10, 8'h1C};  8'd98:  r = {2'b10, 8'h32};  8'd99:  r = {2'b10, 8'h21};
      8'd100: r = {2'b10, 8'h23};  8'd101: r = {2'b10, 8'h24};  8'd102: r = {2'b10, 8'h2B};
      8'd103: r = {2'b10, 8'h34};  8'd104: r = {2'b10, 8'h33};  8'd105: r = {2'b10, 8'h43};
      8'd106: r = {2'b10, 8'h3B};  8'd107: r = {2'b10, 8'h42};  8'd108: r = {2'b10, 8'h4B};
      8'd109: r = {2'b10, 8'h3A};  8'd110: r = {2'b10, 8'h31};  8'd111: r = {2'b10, 8'h44};
      8'd112: r = {2'b10, 8'h4D};  8'd113: r = {2'b10, 8'h15};  8'd114: r = {2'b10, 8'h2D};
      8'd115: r = {2'b10, 8'h1B};  8'd116: r = {2'b10, 8'h2C};  8'd117: r = {2'b10, 8'h3C};
      8'd118: r = {2'b10, 8'h2A};  8'd119: r = {2'b10, 8'h1D};  8'd120: r = {2'b10, 8'h22};
      8'd121: r = {2'b10, 8'h35};  8'd122: r = {2'b10, 8'h1A};
      8'd48:  r = {2'b10, 8'h45};  8'd49:  r = {2'b10, 8'h16};  8'd50:  r = {2'b10, 8'h1E};
      8'd51:  r = {2'b10, 8'h26};  8'd52:  r = {2'b10, 8'h25};  8'd53:  r = {2'b10, 8'h2E};
      8'd54:  r = {2'b10, 8'h36};  8'd55:  r = {2'b10, 8'h3D};  8'd56:  r = {2'b10, 8'h3E};
      8'd57:  r = {2'b10, 8'h46};
      8'd9:   r = {2'b10, 8'h0D};  8'd32:  r = {2'b10, 8'h29};  8'd39:  r = {2'b10, 8'h52};
      8'd44:  r = {2'b10, 8'h41};  8'd45:  r = {2'b10, 8'h4E};  8'd46:  r = {2'b10, 8'h49};
      8'd47:  r = {2'b10, 8'h4A};  8'd59:  r = {2'b10, 8'h4C};  8'd61:  r = {2'b10, 8'h55};
      8'd91:  r = {2'b10, 8'h54};  8'd92:  r = {2'b10, 8'h5D};  8'd93:  r = {2'b10, 8'h5B};
      8'd96:  r = {2'b10, 8'h0E};  8'd128: r = {2'b10, 8'h5A};  8'd129: r = {2'b10, 8'h66};
      8'd130: r = {2'b11, 8'h6B};  8'd131: r = {2'b11, 8'h75};  8'd132: r = {2'b11, 8'h74};
      8'd133: r = {2'b11, 8'h72};  8'd134: r = {2'b11, 8'h6C};
      8'd141: r = {2'b10, 8'h05};  8'd142: r = {2'b10, 8'h06};  8'd143: r = {2'b10, 8'h04};
      8'd144: r = {2'b10, 8'h0C};  8'd145: r = {2'b10, 8'h03};  8'd146: r = {2'b10, 8'h0B};
      8'd147: r = {2'b10, 8'h83};  8'd148: r = {2'b10, 8'h0A};  8'd149: r = {2'b10, 8'h01};
      8'd150: r = {2'b10, 8'h09};  8'd151: r = {2'b10, 8'h78};  8'd152: r = {2'b10, 8'h07};
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef SHIFT_EN
  // Shifted character -> the unshifted character on the same key (0 = none)
  function automatic logic [7:0] shift_base(input logic [7:0] k);
    logic [7:0] r;
    r = 8'd0;
    if (k >= 8'd65 && k <= 8'd90) r = k + 8'd32;
    else begin
      case (k)
        8'd41:  r = 8'd48;  8'd33:  r = 8'd49;  8'd64:  r = 8'd50;  8'd35:  r = 8'd51;
        8'd36:  r = 8'd52;  8'd37:  r = 8'd53;  8'd94:  r = 8'd54;  8'd38:  r = 8'd55;
        8'd42:  r = 8'd56;  8'd40:  r = 8'd57;  8'd95:  r = 8'd45;  8'd43:  r = 8'd61;
        8'd58:  r = 8'd59;  8'd34:  r = 8'd39;  8'd60:  r = 8'd44;  8'd62:  r = 8'd46;
        8'd63:  r = 8'd47;  8'd123: r = 8'd91;  8'd125: r = 8'd93;  8'd124: r = 8'd92;
        8'd126: r = 8'd96;
        default: r = 8'd0;
      endcase
    end
    return r;
  endfunction
`endif

  function automatic logic [7:0] byte_of(input state_t s, input logic [7:0] c);
    logic [7:0] r;
    case (s)
      SH_MK, SH_BK:  r = 8'h12;
      MK_E0, BK_E0:  r = 8'hE0;
      BK_F0, SH_F0:  r = 8'hF0;
      MK, BK:        r = c;
      default:       r = 8'h00;
    endcase
    return r;
  endfunction

  // Lookup on the latched key plus sequence successor logic
  always_comb begin
    m     = base_map(key_q);
    shift = 1'b0;
`ifdef SHIFT_EN
    if (!m[9] && shift_base(key_q) != 8'd0) begin
      m     = base_map(shift_base(key_q));
      shift = 1'b1;
    end
`endif
    hit  = m[9];
    ext  = m[8];
    code = m[7:0];
    first = shift ? SH_MK : (ext ? MK_E0 : MK);
    case (state)
      SH_MK:   nxt = ext ? MK_E0 : MK;
      MK_E0:   nxt = MK;
      MK:      nxt = ext ? BK_E0 : BK_F0;
      BK_E0:   nxt = BK_F0;
      BK_F0:   nxt = BK;
      BK:      nxt = shift ? SH_F0 : IDLE;
      SH_F0:   nxt = SH_BK;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      key_q      <= 8'd0;
      scan_code  <= 8'd0;
      scan_valid <= 1'b0;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      unmapped   <= 1'b0;
      gap_cnt    <= 8'd0;
      gapping    <= 1'b0;
    end else begin
      unmapped <= 1'b0;
      case (state)
        IDLE: if (key_valid) begin
          key_q     <= key_code;
          state     <= LOOK;
          key_ready <= 1'b0;
          busy      <= 1'b1;
        end
        LOOK: if (!hit) begin
          unmapped  <= 1'b1;
          state     <= IDLE;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end else begin
          state      <= first;
          scan_code  <= byte_of(first, code);
          scan_valid <= 1'b1;
        end
        default: begin
          if (gapping) begin
            // Idle spacing between bytes; state already holds the next byte
            if (gap_cnt == 8'd0) begin
              gapping    <= 1'b0;
              scan_valid <= 1'b1;
              scan_code  <= byte_of(state, code);
            end else begin
              gap_cnt <= gap_cnt - 8'd1;
            end
          end else if (scan_valid && scan_ready) begin
            if (nxt == IDLE) begin
              state      <= IDLE;
              scan_valid <= 1'b0;
              scan_code  <= 8'd0;
              key_ready  <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state <= nxt;
              if (BYTE_GAP == 0) begin
                scan_code <= byte_of(nxt, code);
              end else begin
                scan_valid <= 1'b0;
                gapping    <= 1'b1;
                gap_cnt    <= 8'(BYTE_GAP - 1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_to_scan.sv
// Randomized self-checking bench for ascii_to_scan against a table-driven byte-sequence model.
// Two instances: BYTE_GAP=0 and BYTE_GAP=2. Honors SHIFT_EN like the design.
module tb_ascii_to_scan;
  localparam int unsigned GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] key_code, scan_code, g_key_code, g_scan_code;
  logic       key_valid, key_ready, scan_valid, scan_ready, busy, unmapped;
  logic       g_key_valid, g_key_ready, g_scan_valid, g_scan_ready, g_busy, g_unmapped;

  ascii_to_scan #(.BYTE_GAP(0)) dut (
    .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .scan_code(scan_code), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .busy(busy), .unmapped(unmapped));

  ascii_to_scan #(.BYTE_GAP(GAP)) dut_g (
    .clk(clk), .reset(reset), .key_code(g_key_code), .key_valid(g_key_valid),
    .key_ready(g_key_ready), .scan_code(g_scan_code), .scan_valid(g_scan_valid),
    .scan_ready(g_scan_ready), .busy(g_busy), .unmapped(g_unmapped));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_unm, unstable, first_valid_n, ready_low, busy_bad, gap_bad;
  bit timed_out;
  logic [7:0] stall_code;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] arrows [5]   = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C};
  logic [7:0] fkeys [12]   = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                               8'h01, 8'h09, 8'h78, 8'h07};

  // Unshifted make code of a key, -1 when the key has none
  function automatic int base_code(input int k, output bit ext);
    ext = 1'b0;
    if (k >= 97 && k <= 122) return int'(letters[k-97]);
    if (k >= 48 && k <= 57)  return int'(digits[k-48]);
    if (k >= 130 && k <= 134) begin ext = 1'b1; return int'(arrows[k-130]); end
    if (k >= 141 && k <= 152) return int'(fkeys[k-141]);
    case (k)
      9: return 'h0D;    32: return 'h29;   39: return 'h52;   44: return 'h41;
      45: return 'h4E;   46: return 'h49;   47: return 'h4A;   59: return 'h4C;
      61: return 'h55;   91: return 'h54;   92: return 'h5D;   93: return 'h5B;
      96: return 'h0E;   128: return 'h5A;  129: return 'h66;
      default: return -1;
    endcase
  endfunction

`ifdef SHIFT_EN
  function automatic int shifted_to_base(input int k);
    string sp, bp;
    sp = "~)!@#$%^&*(_+:\"<>?{}|";
    bp = "`0123456789-=;',./[]\\";
    if (k >= 65 && k <= 90) return k + 32;
    for (int i = 0; i < sp.len(); i++)
      if (int'(sp[i]) == k) return int'(bp[i]);
    return -1;
  endfunction
`endif

  task automatic model_bytes(input logic [7:0] key);
    int c;
    bit e, sh;
    sh = 1'b0;
    exp_q.delete();
    c = base_code(int'(key), e);
`ifdef SHIFT_EN
    if (c < 0 && shifted_to_base(int'(key)) >= 0) begin
      c  = base_code(shifted_to_base(int'(key)), e);
      sh = 1'b1;
    end
`endif
    if (c < 0) return;
    if (sh) exp_q.push_back(8'h12);
    if (e)  exp_q.push_back(8'hE0);
    exp_q.push_back(8'(c));
    if (e)  exp_q.push_back(8'hE0);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'(c));
    if (sh) begin exp_q.push_back(8'hF0); exp_q.push_back(8'h12); end
  endtask

  function automatic bit q_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive one key into the BYTE_GAP=0 instance and record what comes out
  task automatic do_key(input logic [7:0] k, input int rdy_pct, input int stall, input bit intrude);
    bit rdy, prev_hold;
    logic [7:0] prev_code;
    int stall_left;
    got_q.delete();
    n_unm = 0; unstable = 0; first_valid_n = 0; ready_low = 0; busy_bad = 0;
    timed_out = 1'b0; stall_code = 8'h00; stall_left = stall;
    prev_hold = 1'b0; prev_code = 8'h00;
    key_code = k; key_valid = 1'b1; scan_ready = 1'b0;
    @(posedge clk); #1;
    key_valid = intrude;
    key_code = (k == 8'd122) ? 8'd97 : 8'd122;
    for (int n = 1; n <= 300; n++) begin
      if (scan_valid && prev_hold && scan_code !== prev_code) unstable++;
      if (unmapped) n_unm++;
      if (busy !== !key_ready) busy_bad++;
      if (scan_valid && first_valid_n == 0) first_valid_n = n;
      if (key_ready) begin
        key_valid = 1'b0; scan_ready = 1'b0;
        return;
      end
      ready_low++;
      rdy = (int'($urandom_range(99)) < rdy_pct);
      if (stall_left > 0 && got_q.size() == 1 && scan_valid) begin
        rdy = 1'b0; stall_left--; stall_code = scan_code;
      end
      scan_ready = rdy;
      if (scan_valid && rdy) got_q.push_back(scan_code);
      prev_hold = scan_valid && !rdy;
      prev_code = scan_code;
      @(posedge clk); #1;
    end
    key_valid = 1'b0; scan_ready = 1'b0;
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid got %0b exp 0", scan_valid); end
    checks++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan_code got %02h exp 00", scan_code); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %0b exp 1", key_ready); end
    checks++; if (busy !== 1'b0 || unmapped !== 1'b0) begin errors++; $display("FAIL reset_busy_unmapped got %0b%0b exp 00", busy, unmapped); end
    checks++; if (g_key_ready !== 1'b1 || g_scan_valid !== 1'b0) begin errors++; $display("FAIL reset_gap_inst got rdy=%0b vld=%0b exp 1 0", g_key_ready, g_scan_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    do_key(8'd97, 100, 0, 1'b0);
    model_bytes(8'd97);
    checks++; if (!q_match()) begin errors++; $display("FAIL basic_a_bytes got %0d bytes first %02h exp %0d bytes first 1C", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, exp_q.size()); end
    checks++; if (ready_low != 4) begin errors++; $display("FAIL basic_a_ready_low got %0d exp 4", ready_low); end
    checks++; if (first_valid_n != 2) begin errors++; $display("FAIL basic_a_latency got %0d exp 2", first_valid_n); end
    checks++; if (busy_bad != 0 || timed_out) begin errors++; $display("FAIL basic_a_busy got bad=%0d timeout=%0b exp 0 0", busy_bad, timed_out); end
  endtask

  task automatic test_ext();
    do_key(8'd130, 100, 0, 1'b0);
    model_bytes(8'd130);
    checks++; if (!q_match() || got_q.size() != 5) begin errors++; $display("FAIL ext_left_bytes got %0d bytes exp 5 (E0 6B E0 F0 6B)", got_q.size()); end
    checks++; if (ready_low != 6 || busy_bad != 0) begin errors++; $display("FAIL ext_left_timing got ready_low=%0d busy_bad=%0d exp 6 0", ready_low, busy_bad); end
  endtask

  task automatic test_stall();
    do_key(8'd48, 100, 5, 1'b1);
    model_bytes(8'd48);
    checks++; if (!q_match()) begin errors++; $display("FAIL stall_bytes got %0d bytes exp %0d (45 F0 45)", got_q.size(), exp_q.size()); end
    checks++; if (unstable != 0 || stall_code !== 8'hF0) begin errors++; $display("FAIL stall_hold got unstable=%0d code=%02h exp 0 F0", unstable, stall_code); end
    checks++; if (ready_low != 9 || timed_out) begin errors++; $display("FAIL stall_ready_low got %0d exp 9", ready_low); end
    @(posedge clk); #1;
    checks++; if (scan_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL stall_intruder got vld=%0b rdy=%0b exp 0 1", scan_valid, key_ready); end
  endtask

  task automatic test_unmapped();
    do_key(8'd200, 100, 0, 1'b0);
    checks++; if (n_unm != 1 || first_valid_n != 0 || got_q.size() != 0) begin errors++; $display("FAIL unmapped_200 got pulses=%0d valid_at=%0d bytes=%0d exp 1 0 0", n_unm, first_valid_n, got_q.size()); end
    checks++; if (ready_low != 1) begin errors++; $display("FAIL unmapped_ready got ready_low=%0d exp 1", ready_low); end
    @(posedge clk); #1;
    checks++; if (unmapped !== 1'b0) begin errors++; $display("FAIL unmapped_pulse_width got %0b exp 0", unmapped); end
  endtask

  task automatic test_reset_mid();
    key_code = 8'd131; key_valid = 1'b1; scan_ready = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (scan_valid !== 1'b1 || scan_code !== 8'hE0) begin errors++; $display("FAIL rmid_first_byte got vld=%0b code=%02h exp 1 E0", scan_valid, scan_code); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; scan_ready = 1'b0;
    checks++; if (scan_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abandon got vld=%0b rdy=%0b busy=%0b exp 0 1 0", scan_valid, key_ready, busy); end
    do_key(8'd32, 100, 0, 1'b0);
    model_bytes(8'd32);
    checks++; if (!q_match() || got_q.size() != 3) begin errors++; $display("FAIL rmid_space got %0d bytes first %02h exp 3 first 29", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00); end
  endtask

  task automatic test_random();
    logic [7:0] k;
    for (int i = 0; i < 40; i++) begin
      k = ($urandom_range(1) == 0) ? 8'($urandom_range(152)) : 8'($urandom_range(255));
      do_key(k, 30 + int'($urandom_range(70)), 0, 1'($urandom_range(1)));
      model_bytes(k);
      checks++; if (!q_match() || timed_out) begin errors++; $display("FAIL rand_bytes key=%0d got %0d bytes exp %0d timeout=%0b", k, got_q.size(), exp_q.size(), timed_out); end
      checks++; if (n_unm != ((exp_q.size() == 0) ? 1 : 0) || unstable != 0 || busy_bad != 0) begin errors++; $display("FAIL rand_flags key=%0d got unm=%0d unstable=%0d busy_bad=%0d exp %0d 0 0", k, n_unm, unstable, busy_bad, (exp_q.size() == 0) ? 1 : 0); end
      checks++; if (first_valid_n != ((exp_q.size() == 0) ? 0 : 2)) begin errors++; $display("FAIL rand_latency key=%0d got %0d exp %0d", k, first_valid_n, (exp_q.size() == 0) ? 0 : 2); end
    end
  endtask

  // BYTE_GAP=2 instance, always-ready sink: every byte but the last is followed by GAP empty cycles
  task automatic test_gap(input logic [7:0] k);
    int gap_run;
    got_q.delete();
    n_unm = 0; gap_bad = 0; busy_bad = 0; gap_run = 0; timed_out = 1'b1;
    g_key_code = k; g_key_valid = 1'b1; g_scan_ready = 1'b1;
    @(posedge clk); #1;
    g_key_valid = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (g_unmapped) n_unm++;
      if (g_busy !== !g_key_ready) busy_bad++;
      if (g_key_ready) begin timed_out = 1'b0; break; end
      if (g_scan_valid) begin
        if (got_q.size() > 0 && gap_run != int'(GAP)) gap_bad++;
        got_q.push_back(g_scan_code);
        gap_run = 0;
      end else if (got_q.size() > 0) begin
        gap_run++;
      end
      @(posedge clk); #1;
    end
    model_bytes(k);
    checks++; if (!q_match() || timed_out) begin errors++; $display("FAIL gap_bytes key=%0d got %0d bytes exp %0d timeout=%0b", k, got_q.size(), exp_q.size(), timed_out); end
    checks++; if (gap_bad != 0 || busy_bad != 0) begin errors++; $display("FAIL gap_spacing key=%0d got bad=%0d busy_bad=%0d exp 0 0", k, gap_bad, busy_bad); end
    checks++; if (n_unm != ((exp_q.size() == 0) ? 1 : 0)) begin errors++; $display("FAIL gap_unmapped key=%0d got %0d exp %0d", k, n_unm, (exp_q.size() == 0) ? 1 : 0); end
  endtask

  initial begin
    reset = 1'b1;
    key_code = 8'd0; key_valid = 1'b0; scan_ready = 1'b0;
    g_key_code = 8'd0; g_key_valid = 1'b0; g_scan_ready = 1'b0;
    test_reset();
    test_basic();
    test_ext();
    test_stall();
    test_unmapped();
    test_reset_mid();
    test_random();
    test_gap(8'd65);
    test_gap(8'd97);
    test_gap(8'd130);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
